pll_reconf_seq: RTL and testbench

Sequences safe runtime reprogramming of one S018PLLGS_LC PLL (CPU or SoC) from the I2C control-register bytes in the clk_25m domain.
- Debounces byte-wise register writes.
- Holds the downstream clock-domain reset, gates and bypasses the PLL, and applies the new M/N/OD.
- Waits the lock time, then restores the output and releases the reset.
- One instance per PLL, placed between the i2cSlave outputs and the PLL pins.

---
 rtl/pll_reconf_seq.sv | 195 +++++++++++++++++++
 tb/tb_pll_reconf_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconf_seq.sv
// Runtime reprogramming sequencer for one S018PLLGS_LC PLL (clk_25m domain).
// In: clk, aresetn, req_mul/div/bp/oe. Out: pll_m/n/od/bp/oe, dom_rstn, busy, cfg_err.
module pll_reconf_seq #(
  parameter logic [7:0] DEF_MUL      = 8'd46,
  parameter logic [7:0] DEF_DIV      = 8'h22,
  parameter logic       DEF_BP       = 1'b0,
  parameter logic       DEF_OE       = 1'b0,
  parameter int         SETTLE_CYC   = 16,
  parameter int         RST_LEAD_CYC = 8,
  parameter int         GATE_CYC     = 4,
  parameter int         LOCK_CYC     = 2500,
  parameter int         RST_TAIL_CYC = 8,
  parameter int         CNT_W        = 16
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic [7:0] req_mul,
  input  logic [7:0] req_div,
  input  logic       req_bp,
  input  logic       req_oe,
  output logic [8:0] pll_m,
  output logic [4:0] pll_n,
  output logic [3:0] pll_od,
  output logic       pll_bp,
  output logic       pll_oe,
  output logic       dom_rstn,
  output logic       busy,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_GATE, S_APPLY,
    S_LOCK, S_UNGATE, S_TAIL
  } state_t;

  localparam logic [CNT_W-1:0] L_SET  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] L_LEAD = CNT_W'(RST_LEAD_CYC - 1);
  localparam logic [CNT_W-1:0] L_GATE = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] L_LOCK = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] L_TAIL = CNT_W'(RST_TAIL_CYC - 1);

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_lim;
  logic [15:0]      r_prev, r_sh;
  logic             r_hold;
  logic [7:0]       r_mul, r_div;
  logic             r_bp, r_oe, r_rstn, r_busy, r_err;
  logic [7:0]       w_mul_n, w_div_n;
  logic             w_bp_n, w_oe_n, w_rstn_n, w_busy_n, w_err_n;

  logic [15:0] w_req;
  logic        w_same, w_mis, w_valid, w_arm;
  logic        w_settled, w_go, w_bad, w_done;

  assign w_req     = {req_mul, req_div};
  assign w_same    = (w_req == r_prev);
  assign w_mis     = (w_req != {r_mul, r_div});
  assign w_valid   = (|req_div[4:0]) && (|req_mul);
  // r_hold blocks re-evaluation of a rejected request until it changes
  assign w_arm     = w_same && w_mis && !r_hold;
  assign w_settled = (r_state == S_IDLE) && w_arm && (r_cnt == L_SET);
  assign w_go      = w_settled && w_valid;
  assign w_bad     = w_settled && !w_valid;
  assign w_done    = (r_cnt == w_lim);

  always_comb begin
    w_lim = '0;
    unique case (r_state)
      S_LEAD:  w_lim = L_LEAD;
      S_GATE:  w_lim = L_GATE;
      S_LOCK:  w_lim = L_LOCK;
      S_TAIL:  w_lim = L_TAIL;
      default: w_lim = '0;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_go)   w_nxt = S_LEAD;
      S_LEAD:   if (w_done) w_nxt = S_GATE;
      S_GATE:   if (w_done) w_nxt = S_APPLY;
      S_APPLY:  if (w_done) w_nxt = S_LOCK;
      S_LOCK:   if (w_done) w_nxt = S_UNGATE;
      S_UNGATE: if (w_done) w_nxt = S_TAIL;
      S_TAIL:   if (w_done) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mul_n  = r_mul;
    w_div_n  = r_div;
    w_bp_n   = r_bp;
    w_oe_n   = r_oe;
    w_rstn_n = r_rstn;
    w_busy_n = r_busy;
    w_err_n  = r_err;
    unique case (r_state)
      S_IDLE: begin
        // bp/oe-only changes need no sequence
        if (!w_mis) begin
          w_bp_n = req_bp;
          w_oe_n = req_oe;
        end
        if (w_go) begin
          w_busy_n = 1'b1;
          w_rstn_n = 1'b0;
          w_err_n  = 1'b0;
        end
        if (w_bad) w_err_n = 1'b1;
      end
      S_LEAD: begin
        if (w_done) begin
          w_bp_n = 1'b1;
          w_oe_n = 1'b0;
        end
      end
      S_APPLY: begin
        w_mul_n = r_sh[15:8];
        w_div_n = r_sh[7:0];
      end
      S_UNGATE: begin
        w_bp_n = req_bp;
        w_oe_n = req_oe;
      end
      S_TAIL: begin
        if (w_done) begin
          w_rstn_n = 1'b1;
          w_busy_n = 1'b0;
        end
      end
      default: begin
        w_busy_n = r_busy;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_mul  <= DEF_MUL;
      r_div  <= DEF_DIV;
      r_bp   <= DEF_BP;
      r_oe   <= DEF_OE;
      r_rstn <= 1'b1;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_mul  <= w_mul_n;
      r_div  <= w_div_n;
      r_bp   <= w_bp_n;
      r_oe   <= w_oe_n;
      r_rstn <= w_rstn_n;
      r_busy <= w_busy_n;
      r_err  <= w_err_n;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt  <= '0;
      r_prev <= {DEF_MUL, DEF_DIV};
      r_sh   <= {DEF_MUL, DEF_DIV};
      r_hold <= 1'b0;
    end else begin
      r_prev <= w_req;
      if (r_state == S_IDLE) begin
        r_cnt <= (w_arm && !w_settled) ? r_cnt + 1'b1 : '0;
        if (!w_same)    r_hold <= 1'b0;
        else if (w_bad) r_hold <= 1'b1;
        if (w_go) r_sh <= w_req;
      end else begin
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign pll_m    = {1'b0, r_mul};
  assign pll_n    = r_div[4:0];
  assign pll_od   = {1'b0, r_div[7:5]};
  assign pll_bp   = r_bp;
  assign pll_oe   = r_oe;
  assign dom_rstn = r_rstn;
  assign busy     = r_busy;
  assign cfg_err  = r_err;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Bench for pll_reconf_seq: timeline model checked every cycle
// plus directed literal checks of the sequence milestones.
module tb_pll_reconf_seq;
  localparam int S  = 4;
  localparam int RL = 2;
  localparam int G  = 2;
  localparam int LK = 10;
  localparam int RT = 3;
  localparam int T_GATE  = RL;
  localparam int T_APPLY = RL + G + 1;
  localparam int T_UNG   = T_APPLY + LK + 1;
  localparam int T_END   = T_UNG + RT;

  logic       clk = 1'b0;
  logic       aresetn = 1'b1;
  logic [7:0] req_mul = 8'd46;
  logic [7:0] req_div = 8'h22;
  logic       req_bp = 1'b0;
  logic       req_oe = 1'b0;
  logic [8:0] pll_m;
  logic [4:0] pll_n;
  logic [3:0] pll_od;
  logic       pll_bp, pll_oe, dom_rstn, busy, cfg_err;

  always #20 clk = ~clk;

  pll_reconf_seq #(
    .SETTLE_CYC(S), .RST_LEAD_CYC(RL), .GATE_CYC(G),
    .LOCK_CYC(LK), .RST_TAIL_CYC(RT)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .req_mul(req_mul), .req_div(req_div),
    .req_bp(req_bp), .req_oe(req_oe),
    .pll_m(pll_m), .pll_n(pll_n), .pll_od(pll_od),
    .pll_bp(pll_bp), .pll_oe(pll_oe),
    .dom_rstn(dom_rstn), .busy(busy), .cfg_err(cfg_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [8:0] a,
                     input logic [8:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: k counts edges since a sequence was launched (-1 = idle)
  logic [7:0] m_mul, m_div, sh_mul, sh_div, pv_mul, pv_div;
  logic       m_bp, m_oe, m_err, m_rstn, m_busy, blk, same, mis;
  int         k, stab;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_mul = 8'd46; m_div = 8'h22; m_bp = 0; m_oe = 0;
      m_err = 0; m_rstn = 1; m_busy = 0;
      k = -1; stab = 0; blk = 0;
      pv_mul = 8'd46; pv_div = 8'h22;
      sh_mul = 0; sh_div = 0;
    end else begin
      if (k >= 0) begin
        k++;
        if (k == T_GATE) begin m_bp = 1; m_oe = 0; end
        if (k == T_APPLY) begin m_mul = sh_mul; m_div = sh_div; end
        if (k == T_UNG) begin m_bp = req_bp; m_oe = req_oe; end
        if (k == T_END) begin m_rstn = 1; m_busy = 0; k = -1; end
      end else begin
        same = (req_mul == pv_mul) && (req_div == pv_div);
        mis  = (req_mul != m_mul) || (req_div != m_div);
        if (!same) blk = 0;
        if (same && mis && !blk) stab++;
        else stab = 0;
        if (!mis) begin m_bp = req_bp; m_oe = req_oe; end
        if (stab == S) begin
          stab = 0;
          if (req_mul != 0 && req_div[4:0] != 0) begin
            sh_mul = req_mul; sh_div = req_div;
            m_err = 0; m_busy = 1; m_rstn = 0; k = 0;
          end else begin
            m_err = 1; blk = 1;
          end
        end
      end
      pv_mul = req_mul; pv_div = req_div;
    end
  end

  always @(negedge clk) begin
    if ($time > 10) begin
      chk("m", pll_m, {1'b0, m_mul});
      chk("n", 9'(pll_n), 9'(m_div[4:0]));
      chk("od", 9'(pll_od), 9'(m_div[7:5]));
      chk("bp", 9'(pll_bp), 9'(m_bp));
      chk("oe", 9'(pll_oe), 9'(m_oe));
      chk("rstn", 9'(dom_rstn), 9'(m_rstn));
      chk("busy", 9'(busy), 9'(m_busy));
      chk("err", 9'(cfg_err), 9'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(1);
    chk("L_rst_m", pll_m, 9'd46);
    chk("L_rst_n", 9'(pll_n), 9'd2);
    chk("L_rst_od", 9'(pll_od), 9'd1);
    chk("L_rst_oe", 9'(pll_oe), 9'd0);
    chk("L_rst_rstn", 9'(dom_rstn), 9'd1);
    chk("L_rst_busy", 9'(busy), 9'd0);

    // full sequence
    req_mul = 8'd30; req_div = 8'h21; req_oe = 1'b1;
    tick(4); chk("L1_nobusy", 9'(busy), 9'd0);
    tick(1); chk("L1_busy", 9'(busy), 9'd1);
    chk("L1_rstn", 9'(dom_rstn), 9'd0);
    tick(2); chk("L1_bp", 9'(pll_bp), 9'd1);
    chk("L1_oe", 9'(pll_oe), 9'd0);
    chk("L1_m_old", pll_m, 9'd46);
    tick(3); chk("L1_m", pll_m, 9'd30);
    chk("L1_n", 9'(pll_n), 9'd1);
    chk("L1_od", 9'(pll_od), 9'd1);
    tick(10); chk("L1_oe_lock", 9'(pll_oe), 9'd0);
    tick(1); chk("L1_oe_on", 9'(pll_oe), 9'd1);
    tick(2); chk("L1_rstn_tail", 9'(dom_rstn), 9'd0);
    tick(1); chk("L1_rstn_rel", 9'(dom_rstn), 9'd1);
    chk("L1_busy_end", 9'(busy), 9'd0);

    // byte-wise write debounce
    tick(3);
    req_mul = 8'd20;
    tick(2);
    req_div = 8'h43;
    tick(4); chk("L2_nobusy", 9'(busy), 9'd0);
    tick(1); chk("L2_busy", 9'(busy), 9'd1);
    tick(20);
    chk("L2_m", pll_m, 9'd20);
    chk("L2_n", 9'(pll_n), 9'd3);
    chk("L2_od", 9'(pll_od), 9'd2);

    // invalid request, then corrected
    req_div = 8'h40;
    tick(4); chk("L3_err0", 9'(cfg_err), 9'd0);
    tick(1); chk("L3_err1", 9'(cfg_err), 9'd1);
    chk("L3_nobusy", 9'(busy), 9'd0);
    tick(10); chk("L3_hold", 9'(busy), 9'd0);
    chk("L3_n", 9'(pll_n), 9'd3);
    req_div = 8'h24;
    tick(4); chk("L3_err_kept", 9'(cfg_err), 9'd1);
    tick(1); chk("L3_err_clr", 9'(cfg_err), 9'd0);
    chk("L3_busy", 9'(busy), 9'd1);
    tick(20);
    chk("L3_n_new", 9'(pll_n), 9'd4);

    // write during LOCK: last write wins afterwards
    req_mul = 8'd50;
    tick(5); chk("L4_busy", 9'(busy), 9'd1);
    tick(8);
    req_mul = 8'd60;
    tick(11); chk("L4_done", 9'(busy), 9'd0);
    chk("L4_m1", pll_m, 9'd50);
    tick(3); chk("L4_idle", 9'(busy), 9'd0);
    tick(1); chk("L4_busy2", 9'(busy), 9'd1);
    tick(20); chk("L4_m2", pll_m, 9'd60);

    // bp/oe only change
    req_oe = 1'b0;
    tick(1); chk("L5_oe0", 9'(pll_oe), 9'd0);
    chk("L5_rstn", 9'(dom_rstn), 9'd1);
    req_oe = 1'b1; req_bp = 1'b1;
    tick(1); chk("L5_oe1", 9'(pll_oe), 9'd1);
    chk("L5_bp1", 9'(pll_bp), 9'd1);
    chk("L5_nobusy", 9'(busy), 9'd0);
    req_bp = 1'b0;
    tick(1);

    // async reset during LOCK
    req_mul = 8'd70;
    tick(5); chk("L6_busy", 9'(busy), 9'd1);
    tick(8);
    #2 aresetn = 1'b0;
    #1;
    chk("L6_m", pll_m, 9'd46);
    chk("L6_n", 9'(pll_n), 9'd2);
    chk("L6_rstn", 9'(dom_rstn), 9'd1);
    chk("L6_busy0", 9'(busy), 9'd0);
    chk("L6_oe", 9'(pll_oe), 9'd0);
    req_mul = 8'd46; req_div = 8'h22;
    req_bp = 1'b0; req_oe = 1'b0;
    tick(1);
    aresetn = 1'b1;
    tick(6);
    chk("L6_idle", 9'(busy), 9'd0);
    chk("L6_m_def", pll_m, 9'd46);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
